// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and entry type for the instruction-fetch stage
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO with flush and occupancy count
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  entry_t        din_i,
  output entry_t        dout_o,
  output logic [CW-1:0] count_o
);
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  entry_t        mem_q [DEPTH];
  // pointer and count update; flush empties the queue in one cycle
  always_comb begin
    wr_d  = flush_i ? '0 : wr_q + AW'(push_i);
    rd_d  = flush_i ? '0 : rd_q + AW'(pop_i);
    cnt_d = flush_i ? '0 : cnt_q + CW'(push_i) - CW'(pop_i);
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= din_i;
  end
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: fetch PC, credit-limited imem requests, redirect squash and decode queue
module fetch_queue_stage #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] pc_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);
  import fetch_pkg::*;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_ent_t;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, tgt;
  logic [CW-1:0]   inflight_q, inflight_d, drop_q, drop_d, count;
  logic            accept, resp_drop, enq, deq;
  fetch_ent_t      head, din;
  logic            unused;
  assign unused    = ^pc_target[1:0];
  assign tgt       = {pc_target[XLEN-1:2], 2'b00};
  assign imem_req  = !redirect && (({1'b0, count} + {1'b0, inflight_q}) < CAP);
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req && imem_ready;
  assign resp_drop = imem_rvalid && (drop_q != '0);
  assign enq       = imem_rvalid && !resp_drop && !redirect;
  assign deq       = instr_valid && instr_ready && !redirect;
  assign din       = '{pc: resp_pc_q, instr: imem_rdata};
  assign instr_valid = count != '0;
  assign instr     = instr_valid ? head.instr : NOP_INSTR;
  assign pc        = instr_valid ? head.pc : '0;
  assign pc_plus4  = instr_valid ? head.pc + XLEN'(4) : '0;
  // next state: redirect reloads both PCs and turns every outstanding response into a drop
  always_comb begin
    fetch_pc_d = redirect ? tgt : accept ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    resp_pc_d  = redirect ? tgt : enq ? resp_pc_q + XLEN'(4) : resp_pc_q;
    inflight_d = inflight_q + CW'(accept) - CW'(imem_rvalid);
    drop_d     = redirect ? inflight_q - CW'(imem_rvalid) : drop_q - CW'(resp_drop);
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH), .entry_t(fetch_ent_t)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (enq),
    .pop_i   (deq),
    .flush_i (redirect),
    .din_i   (din),
    .dout_o  (head),
    .count_o (count)
  );
endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb_fetch_queue_stage: queue-level reference model plus directed scenarios for the fetch stage
module tb_fetch_queue_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk, rst, redirect, imem_req, imem_ready, imem_rvalid, instr_valid, instr_ready;
  logic [31:0] pc_target, imem_addr, imem_rdata, instr, pc, pc_plus4;

  fetch_queue_stage #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .pc_target(pc_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc(pc), .pc_plus4(pc_plus4)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] addr; bit stale; } oreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  mreq_t memq[$];
  oreq_t os[$];
  ent_t  mq[$];
  logic [31:0] mpc;
  int cyc, lat, acc_cnt, acc0, pass_cnt, total;
  bit mvalid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
  endtask

  task automatic check_model();
    bit v;
    if (!mvalid) return;
    v = mq.size() > 0;
    chk("imem_req", {31'b0, imem_req}, {31'b0, !redirect && (mq.size() + os.size() < 4)});
    if (!redirect && (mq.size() + os.size() < 4)) chk("imem_addr", imem_addr, mpc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, v});
    chk("instr", instr, v ? mq[0].ins : NOP);
    chk("pc", pc, v ? mq[0].pc : 32'h0);
    chk("pc_plus4", pc_plus4, v ? mq[0].pc + 32'd4 : 32'h0);
  endtask

  task automatic update();
    bit req;
    oreq_t o;
    req = !redirect && (mq.size() + os.size() < 4);
    if (rst) begin
      mq.delete(); os.delete(); mpc = 32'h0; mvalid = 1;
    end else if (mvalid) begin
      if (redirect) begin
        if (imem_rvalid && os.size() > 0) void'(os.pop_front());
        foreach (os[i]) os[i].stale = 1;
        mq.delete();
        mpc = {pc_target[31:2], 2'b00};
      end else begin
        if (mq.size() > 0 && instr_ready) void'(mq.pop_front());
        if (imem_rvalid && os.size() > 0) begin
          o = os.pop_front();
          if (!o.stale) mq.push_back('{o.addr, mem_word(o.addr)});
        end
        if (req && imem_ready) begin
          os.push_back('{mpc, 1'b0});
          mpc += 32'd4;
        end
      end
    end
    if (rst) memq.delete();
    else begin
      if (imem_rvalid) void'(memq.pop_front());
      if (imem_req && imem_ready) begin
        memq.push_back('{imem_addr, cyc + lat});
        acc_cnt++;
      end
    end
  endtask

  task automatic drive_mem();
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rvalid = 1; imem_rdata = mem_word(memq[0].addr);
    end else begin
      imem_rvalid = 0; imem_rdata = 32'hDEAD_BEEF;
    end
  endtask

  task automatic tick();
    #1;
    check_model();
    update();
    @(posedge clk);
    #1;
    cyc++;
    drive_mem();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    rst = 1; redirect = 0; pc_target = 0; imem_ready = 1; instr_ready = 1;
    imem_rvalid = 0; imem_rdata = 0; lat = 1; cyc = 0; mvalid = 0;
    pass_cnt = 0; total = 0; acc_cnt = 0; mpc = 0;
    @(negedge clk);
    tick();
    redirect = 1; pc_target = 32'h0000_0444;
    tick();
    rst = 0; redirect = 0;
    // reset state and sequential stream, latency 1
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h0);
    tick();
    #1; chk("seq_addr1", imem_addr, 32'h4); chk("seq_nop", instr, NOP); tick();
    #1; chk("seq_addr2", imem_addr, 32'h8); chk("seq_pc0", pc, 32'h0);
    chk("seq_instr0", instr, 32'hC0DE_0000); tick();
    #1; chk("seq_pc1", pc, 32'h4); chk("seq_pc4_1", pc_plus4, 32'h8); tick();
    repeat (6) tick();
    // decode back-pressure: exactly DEPTH accepts, resume after first pop
    instr_ready = 0;
    do_reset();
    acc0 = acc_cnt;
    repeat (8) tick();
    chk("bp_accepts", acc_cnt - acc0, 32'd4);
    #1; chk("bp_req_low", {31'b0, imem_req}, 32'd0);
    instr_ready = 1;
    #1; chk("bp_req_hold", {31'b0, imem_req}, 32'd0);
    tick();
    #1; chk("bp_resume", {31'b0, imem_req}, 32'd1);
    repeat (6) tick();
    // latency 3, redirect with two requests in flight
    lat = 3;
    do_reset();
    tick(); tick();
    redirect = 1; pc_target = 32'h0000_0103;
    #1; chk("rd_req_low", {31'b0, imem_req}, 32'd0);
    tick();
    redirect = 0;
    #1; chk("rd_addr", imem_addr, 32'h100);
    repeat (4) begin #1; chk("rd_nv", {31'b0, instr_valid}, 32'd0); tick(); end
    #1; chk("rd_valid", {31'b0, instr_valid}, 32'd1);
    chk("rd_pc", pc, 32'h100); chk("rd_instr", instr, 32'hC0DE_0100);
    tick();
    repeat (6) tick();
    // redirect coinciding with a response and a pop
    lat = 1;
    do_reset();
    tick(); tick();
    #1; chk("rs_pre_valid", {31'b0, instr_valid}, 32'd1);
    redirect = 1; pc_target = 32'h0000_0200;
    tick();
    redirect = 0;
    #1; chk("rs_empty", {31'b0, instr_valid}, 32'd0); chk("rs_addr", imem_addr, 32'h200); tick();
    #1; chk("rs_empty2", {31'b0, instr_valid}, 32'd0); tick();
    #1; chk("rs_pc", pc, 32'h200); tick();
    repeat (3) tick();
    // PC wrap-around
    redirect = 1; pc_target = 32'hFFFF_FFFC;
    tick();
    redirect = 0;
    #1; chk("wr_addr0", imem_addr, 32'hFFFF_FFFC); tick();
    #1; chk("wr_addr1", imem_addr, 32'h0); tick();
    #1; chk("wr_pc", pc, 32'hFFFF_FFFC); chk("wr_pc4", pc_plus4, 32'h0); tick();
    #1; chk("wr_pc_b", pc, 32'h0); chk("wr_pc4_b", pc_plus4, 32'h4); tick();
    repeat (3) tick();
    // reset with full credit and responses outstanding, redirect also asserted
    lat = 3; instr_ready = 0;
    do_reset();
    repeat (5) tick();
    rst = 1; redirect = 1; pc_target = 32'h0000_0300;
    tick();
    rst = 0; redirect = 0; instr_ready = 1;
    #1;
    chk("rm_valid", {31'b0, instr_valid}, 32'd0);
    chk("rm_addr", imem_addr, 32'h0);
    chk("rm_req", {31'b0, imem_req}, 32'd1);
    tick();
    repeat (3) begin #1; chk("rm_late", {31'b0, instr_valid}, 32'd0); tick(); end
    #1; chk("rm_pc", pc, 32'h0); tick();
    // mixed traffic
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) lat = $urandom_range(1, 4);
      imem_ready  = ($urandom % 4) != 0;
      instr_ready = ($urandom % 3) != 0;
      redirect    = ($urandom % 16) == 0;
      pc_target   = $urandom;
      rst         = ($urandom % 97) == 0;
      tick();
    end
    rst = 0; redirect = 0;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
